// File: rtl/botoes_pkg.sv
// Shared definitions for the push-button input conditioner.
package botoes_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    SOLTO      = 2'd0,
    CONF_PRESS = 2'd1,
    PRESO      = 2'd2,
    CONF_SOLTA = 2'd3
  } estado_t;

  // Button index constants (KEY order).
  localparam int unsigned BTN_A = 0;
  localparam int unsigned BTN_B = 1;
  localparam int unsigned BTN_C = 2;
  localparam int unsigned BTN_D = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_canal.sv
// One button channel: 2-FF synchronizer, debounce FSM, auto-repeat counter.
// All outputs are registered; raw_i is active-low (0 = pressed).
module debounce_canal
  import botoes_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] REP_ONE    = RW'(1);
  localparam logic [RW-1:0] REP_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_PERIOD = RW'(REPEAT_PERIOD);

  logic          s1_q, s2_q;
  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  // State, counters, synchronizer and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      estado_q  <= SOLTO;
      cnt_q     <= '0;
      rep_q     <= '0;
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // Next-state, counter updates and one-cycle pulse generation.
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (estado_q)
      SOLTO: begin
        if (!s2_q) begin
          estado_d = CONF_PRESS;
          cnt_d    = CNT_ONE;
        end
      end
      CONF_PRESS: begin
        if (s2_q) begin
          estado_d = SOLTO;
          cnt_d    = '0;
        end else if (cnt_q >= CNT_LAST) begin
          estado_d = PRESO;
          level_d  = 1'b0;
          press_d  = 1'b1;
          repeat_d = 1'b1;
          rep_d    = REP_DELAY;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESO: begin
        // Release candidate takes priority: the repeat counter is frozen,
        // so a tick can never land on the same cycle as a release.
        if (s2_q) begin
          estado_d = CONF_SOLTA;
          cnt_d    = CNT_ONE;
        end else if (rep_q == REP_ONE) begin
          repeat_d = 1'b1;
          rep_d    = REP_PERIOD;
        end else if (rep_q != '0) begin
          rep_d = rep_q - RW'(1);
        end
      end
      CONF_SOLTA: begin
        if (!s2_q) begin
          estado_d = PRESO;
        end else if (cnt_q >= CNT_LAST) begin
          estado_d  = SOLTO;
          level_d   = 1'b1;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: estado_d = SOLTO;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/entrada_botoes.sv
// Input conditioner for the KEY push-buttons: one debounce channel per key.
module entrada_botoes
  import botoes_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_canal
    debounce_canal #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_canal (
      .clk_i    (clk),
      .reset_i  (reset),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_entrada_botoes.sv
// Directed self-checking bench for entrada_botoes (D=4, delay=20, period=8).
module tb_entrada_botoes;

  logic       clk;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_repeat;

  int unsigned n_tests;
  int unsigned n_fail;

  entrada_botoes #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel, input logic [3:0] rep);
    chk({tag, ".level"},   btn_level,   lvl);
    chk({tag, ".press"},   btn_press,   prs);
    chk({tag, ".release"}, btn_release, rel);
    chk({tag, ".repeat"},  btn_repeat,  rep);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    btn_raw = 4'hF;

    // Reset values held for 3 cycles and after deassertion.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("reset", 4'hF, 4'h0, 4'h0, 4'h0);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("idle", 4'hF, 4'h0, 4'h0, 4'h0);
    end

    // Clean press on A: accepted on the 6th edge after the change.
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all("pressA", (k >= 6) ? 4'hE : 4'hF, (k == 6) ? 4'h1 : 4'h0,
              4'h0, (k == 6) ? 4'h1 : 4'h0);
    end
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all("releaseA", (k >= 6) ? 4'hF : 4'hE, 4'h0,
              (k == 6) ? 4'h1 : 4'h0, 4'h0);
    end

    // Bounce on B: low/high in 2-cycle runs never reaches the debounce count.
    for (int k = 0; k < 16; k++) begin
      btn_raw[1] = (k < 8) ? k[1] : 1'b1;
      tick();
      chk_all("bounceB", 4'hF, 4'h0, 4'h0, 4'h0);
    end

    // Auto-repeat on C: press at edge 6, ticks at +20, then every 8.
    btn_raw[2] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk("holdC.repeat", btn_repeat,
          (k == 6 || k == 26 || k == 34 || k == 42 || k == 50 || k == 58) ? 4'h4 : 4'h0);
      chk("holdC.level", btn_level, (k >= 6) ? 4'hB : 4'hF);
    end
    btn_raw[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_all("releaseC", (k >= 6) ? 4'hF : 4'hB, 4'h0,
              (k == 6) ? 4'h4 : 4'h0, 4'h0);
    end

    // Simultaneous presses on A and D.
    btn_raw = 4'h6;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all("simulAD", (k >= 6) ? 4'h6 : 4'hF, (k == 6) ? 4'h9 : 4'h0,
              4'h0, (k == 6) ? 4'h9 : 4'h0);
    end

    // Reset while A and D are held: outputs clear, fresh press afterwards.
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("resetHeld", 4'hF, 4'h0, 4'h0, 4'h0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all("repressAD", (k >= 6) ? 4'h6 : 4'hF, (k == 6) ? 4'h9 : 4'h0,
              4'h0, (k == 6) ? 4'h9 : 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
